// File: rtl/skew_feeder_if.sv
// Load/stream bus of skew_feeder: element write port, start/busy/done control,
// and the skewed wavefront output beat channel.
interface skew_feeder_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 9
) ();
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [2*DW-1:0]         wr_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*2*DW-1:0]   out_data;
    logic                    out_first;
    logic                    out_last;

    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  busy, done, out_valid, out_data, out_first, out_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output busy, done, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/skew_feeder.sv
// Holds a LANES x DEPTH complex matrix and streams it as diagonal-skewed wavefront beats.
// Optional SKEW_FEEDER_LOOP_EN adds a loop input that restarts the stream without an idle gap.
module skew_feeder #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 9
) (
    input  logic clk,
    input  logic rst,
`ifdef SKEW_FEEDER_LOOP_EN
    input  logic loop,
`endif
    skew_feeder_if.slave bus
);
    localparam int unsigned EW = 2 * DW;
    localparam int unsigned OW = LANES * EW;
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned RW = $clog2(DEPTH);
    localparam logic [AW:0] LAST_T = (AW+1)'(LANES + DEPTH - 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_n;
    logic [AW:0]    t, t_n;
    logic [OW-1:0]  out_data_q, out_data_n;
    logic           first_q, first_n;
    logic           last_q, last_n;
    logic           done_q, done_n;

    logic           load;
    logic [AW:0]    load_t;
    logic [OW-1:0]  beat;

    logic [EW-1:0]  mem [LANES][DEPTH];

    logic           wr_ok;
    logic [LW-1:0]  wr_lane;
    logic [RW-1:0]  wr_row;

    assign wr_lane = bus.wr_addr[LW-1:0];
    assign wr_row  = bus.wr_addr[LW +: RW];
    assign wr_ok   = bus.wr_en && (state == IDLE) &&
                     ({1'b0, bus.wr_addr} < (AW+1)'(LANES * DEPTH));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_lane][wr_row] <= bus.wr_data;
        end
    end

    // Beat index about to be loaded: next t while running, beat 0 on start or loop wrap.
    assign load_t = (state == RUN && t != LAST_T) ? t + 1'b1 : '0;

    logic signed [AW:0] r;
    logic [RW-1:0]      row;

    // The write bypass lets a write issued alongside start land in beat 0.
    always_comb begin
        beat = '0;
        r    = '0;
        row  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r   = $signed(load_t) - $signed((AW+1)'(i));
            row = r[RW-1:0];
            if (!r[AW] && (r < $signed((AW+1)'(DEPTH)))) begin
                if (wr_ok && wr_lane == LW'(i) && wr_row == row) begin
                    beat[i*EW +: EW] = bus.wr_data;
                end else begin
                    beat[i*EW +: EW] = mem[LW'(i)][row];
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        t_n        = t;
        out_data_n = out_data_q;
        first_n    = first_q;
        last_n     = last_q;
        done_n     = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    if (t == LAST_T) begin
                        done_n = 1'b1;
`ifdef SKEW_FEEDER_LOOP_EN
                        if (loop) begin
                            load = 1'b1;
                        end else begin
                            state_n    = IDLE;
                            t_n        = '0;
                            out_data_n = '0;
                            first_n    = 1'b0;
                            last_n     = 1'b0;
                        end
`else
                        state_n    = IDLE;
                        t_n        = '0;
                        out_data_n = '0;
                        first_n    = 1'b0;
                        last_n     = 1'b0;
`endif
                    end else begin
                        load = 1'b1;
                    end
                end
            end
        endcase
        if (load) begin
            t_n        = load_t;
            out_data_n = beat;
            first_n    = (load_t == '0);
            last_n     = (load_t == LAST_T);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            t          <= '0;
            out_data_q <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            t          <= t_n;
            out_data_q <= out_data_n;
            first_q    <= first_n;
            last_q     <= last_n;
            done_q     <= done_n;
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.out_valid = (state == RUN);
    assign bus.out_data  = out_data_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_skew_feeder.sv
// Randomized self-checking bench for skew_feeder against a flat-memory wavefront model.
// Covers preload, backpressure, blocked writes, mid-run reset, start-on-done and write+start.
module tb_skew_feeder;
    localparam int unsigned LANES  = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 9;
    localparam int unsigned EW     = 2 * DW;
    localparam int unsigned OW     = LANES * EW;
    localparam int          NBEATS = LANES + DEPTH - 1;
    localparam int          NELEM  = LANES * DEPTH;

    logic clk = 1'b0;
    logic rst;
`ifdef SKEW_FEEDER_LOOP_EN
    logic loop;
`endif

    skew_feeder_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

    skew_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
`ifdef SKEW_FEEDER_LOOP_EN
        .loop(loop),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] ref_mem [NELEM];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_beat(input int t);
        logic [OW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            int r;
            r = t - i;
            if (r >= 0 && r < int'(DEPTH)) v[i*EW +: EW] = ref_mem[r*LANES + i];
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Assumes beat 0 is currently presented; mode 0 = always ready, 1 = stall beat 10, 2 = random.
    task automatic consume(input int mode, input bit keep_start, input bit wr_probe, input bit spot);
        int k = 0;
        int cyc = 0;
        int held = 0;
        bit rdy;
        if (keep_start) bus.start = 1'b1;
        if (wr_probe) begin
            bus.wr_addr = '0;
            bus.wr_data = '1;
        end
        while (k < NBEATS && cyc < 2000) begin
            case (mode)
                1:       begin rdy = !(k == 10 && held < 3); if (!rdy) held++; end
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            bus.out_ready = rdy;
            if (wr_probe) bus.wr_en = (k == 30);
            check("beat_valid", OW'(bus.out_valid), OW'(1));
            check("beat_busy",  OW'(bus.busy), OW'(1));
            check("beat_data",  bus.out_data, exp_beat(k));
            check("beat_first", OW'(bus.out_first), OW'(k == 0));
            check("beat_last",  OW'(bus.out_last), OW'(k == NBEATS - 1));
            if (spot && k == 0)  check("b0_lane0", OW'(bus.out_data[31:0]), OW'(32'h0000_1000));
            if (spot && k == 7) begin
                check("b7_lane0", OW'(bus.out_data[31:0]), OW'(32'h0038_1038));
                check("b7_lane7", OW'(bus.out_data[255:224]), OW'(32'h0007_1007));
            end
            if (spot && k == NBEATS - 1) check("b70_data", bus.out_data, {32'h01FF_11FF, 224'h0});
            step();
            if (rdy) k++;
            cyc++;
        end
        bus.wr_en = 1'b0;
        bus.out_ready = 1'b1;
        check("beat_count", OW'(k), OW'(NBEATS));
        check("done_pulse", OW'(bus.done), OW'(1));
        check("done_busy",  OW'(bus.busy), OW'(0));
        check("done_valid", OW'(bus.out_valid), OW'(0));
        check("done_data",  bus.out_data, '0);
        check("done_last",  OW'(bus.out_last), OW'(0));
        step();
        check("done_once",  OW'(bus.done), OW'(0));
    endtask

    initial begin
        logic [EW-1:0] newd;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.out_ready = 1'b0;
`ifdef SKEW_FEEDER_LOOP_EN
        loop = 1'b0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_busy",  OW'(bus.busy), OW'(0));
        check("rst_done",  OW'(bus.done), OW'(0));
        check("rst_valid", OW'(bus.out_valid), OW'(0));
        check("rst_first", OW'(bus.out_first), OW'(0));
        check("rst_last",  OW'(bus.out_last), OW'(0));
        check("rst_data",  bus.out_data, '0);
        step();
        rst = 1'b1;
        step();

        for (int a = 0; a < NELEM; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = {16'(a), 16'(a + 32'h1000)};
            ref_mem[a]  = {16'(a), 16'(a + 32'h1000)};
            step();
        end
        bus.wr_en = 1'b0;
        bus.out_ready = 1'b1;

        start_pulse();
        consume(0, 1'b0, 1'b0, 1'b1);

        start_pulse();
        consume(1, 1'b0, 1'b0, 1'b1);

        start_pulse();
        consume(0, 1'b0, 1'b1, 1'b1);
        start_pulse();
        check("run_write_dropped", OW'(bus.out_data[31:0]), OW'(32'h0000_1000));
        consume(2, 1'b0, 1'b0, 1'b1);

        start_pulse();
        repeat (20) step();
        check("pre_reset_beat", bus.out_data, exp_beat(20));
        #3 rst = 1'b0;
        #1;
        check("mid_rst_valid", OW'(bus.out_valid), OW'(0));
        check("mid_rst_busy",  OW'(bus.busy), OW'(0));
        check("mid_rst_data",  bus.out_data, '0);
        check("mid_rst_done",  OW'(bus.done), OW'(0));
        repeat (2) begin
            step();
            check("rst_hold_done",  OW'(bus.done), OW'(0));
            check("rst_hold_valid", OW'(bus.out_valid), OW'(0));
        end
        rst = 1'b1;
        step();
        check("post_rst_done", OW'(bus.done), OW'(0));
        check("post_rst_busy", OW'(bus.busy), OW'(0));
        start_pulse();
        check("replay_beat0", bus.out_data, exp_beat(0));
        consume(2, 1'b0, 1'b0, 1'b1);

        bus.start = 1'b1;
        step();
        consume(2, 1'b1, 1'b0, 1'b1);
        bus.start = 1'b0;
        check("restart_first", OW'(bus.out_first), OW'(1));
        check("restart_valid", OW'(bus.out_valid), OW'(1));
        consume(0, 1'b0, 1'b0, 1'b1);

        newd = EW'($urandom);
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = newd; bus.start = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        ref_mem[0] = newd;
        check("wr_start_lane0", OW'(bus.out_data[31:0]), OW'(newd));
        consume(2, 1'b0, 1'b0, 1'b0);

`ifdef SKEW_FEEDER_LOOP_EN
        loop = 1'b1;
        start_pulse();
        for (int k = 0; k < NBEATS; k++) begin
            check("loop_data", bus.out_data, exp_beat(k));
            step();
        end
        check("loop_done",  OW'(bus.done), OW'(1));
        check("loop_valid", OW'(bus.out_valid), OW'(1));
        check("loop_busy",  OW'(bus.busy), OW'(1));
        check("loop_first", OW'(bus.out_first), OW'(1));
        check("loop_beat0", bus.out_data, exp_beat(0));
        loop = 1'b0;
        consume(0, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
